// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin req/gnt arbiter with registered one-hot grant and a bounded tenure under contention.
// Every ownership change passes through a one-cycle gap with gnt low.
module rr_req_gnt_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             preempt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam int CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [N_REQ-1:0] ONE       = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [CNT_W-1:0] hold_cnt;
  logic [ID_W-1:0]  last;

  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic             owner_req;
  logic             others_wait;

  // Rotating search starting just after the previous winner.
  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] cand;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx  = (32'(last) + k) % N_REQ;
      cand = ID_W'(idx);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    owner_req   = req[gnt_id];
    others_wait = |(req & ~gnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      preempt  <= 1'b0;
      hold_cnt <= '0;
      last     <= ID_W'(N_REQ - 1);
    end else begin
      case (state)
        GRANT: begin
          if (!owner_req) begin
            // Release takes priority over a preemption due on the same edge.
            state   <= GAP;
            gnt     <= '0;
            busy    <= 1'b0;
            preempt <= 1'b0;
          end else if (hold_cnt == HOLD_LAST && others_wait) begin
            state   <= GAP;
            gnt     <= '0;
            busy    <= 1'b0;
            preempt <= 1'b1;
          end else begin
            preempt <= 1'b0;
            if (hold_cnt != HOLD_LAST) begin
              hold_cnt <= hold_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          preempt <= 1'b0;
          if (win_found) begin
            state    <= GRANT;
            gnt      <= ONE << win_id;
            gnt_id   <= win_id;
            busy     <= 1'b1;
            last     <= win_id;
            hold_cnt <= '0;
          end else begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// Directed testbench for rr_req_gnt_arbiter (N_REQ=4, MAX_HOLD=8) with hand-computed expectations.
module tb_rr_req_gnt_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       preempt;

  int n_tests;
  int n_fail;

  rr_req_gnt_arbiter #(.N_REQ(4), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] g, input logic [1:0] id,
                             input logic p);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".busy"}, 32'(busy), 32'(|g));
    if (|g) chk({tag, ".gnt_id"}, 32'(gnt_id), 32'(id));
    chk({tag, ".preempt"}, 32'(preempt), 32'(p));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 4'b0000;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] oh;
    n_tests = 0;
    n_fail  = 0;
    req     = 4'b0000;
    rst     = 1'b1;
    #12;

    // T1: reset values, then single-cycle grant latency
    check_state("T1.rst", 4'b0000, 2'd0, 1'b0);
    chk("T1.rst.gnt_id", 32'(gnt_id), 32'd0);
    rst = 1'b0;
    tick();
    check_state("T1.idle", 4'b0000, 2'd0, 1'b0);
    req = 4'b0001;
    tick();
    check_state("T1.grant", 4'b0001, 2'd0, 1'b0);

    // T2: full contention, 8-cycle tenure, gap with preempt pulse, rotation 0,1,2,3,0
    tick();
    do_reset();
    req = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      oh = 4'b0001 << (o % 4);
      for (int c = 0; c < 8; c++) begin
        tick();
        check_state($sformatf("T2.o%0d.c%0d", o, c), oh, 2'(o % 4), 1'b0);
      end
      tick();
      check_state($sformatf("T2.o%0d.gap", o), 4'b0000, 2'd0, 1'b1);
    end

    // T3: voluntary release after 3 cycles while req[2] waits
    do_reset();
    req = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_state($sformatf("T3.c%0d", c), 4'b0001, 2'd0, 1'b0);
    end
    req = 4'b0100;
    tick();
    check_state("T3.gap", 4'b0000, 2'd0, 1'b0);
    tick();
    check_state("T3.next", 4'b0100, 2'd2, 1'b0);

    // T4: lone requester keeps the grant past MAX_HOLD
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      tick();
      check_state($sformatf("T4.c%0d", c), 4'b0010, 2'd1, 1'b0);
    end

    // T5: asynchronous reset mid-grant, then priority restarts at req[0]
    do_reset();
    req = 4'b0011;
    tick();
    tick();
    check_state("T5.pre", 4'b0001, 2'd0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_state("T5.async", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    req = 4'b1001;
    tick();
    check_state("T5.first", 4'b0001, 2'd0, 1'b0);
    req = 4'b1000;
    tick();
    check_state("T5.gap", 4'b0000, 2'd0, 1'b0);
    tick();
    check_state("T5.second", 4'b1000, 2'd3, 1'b0);

    // T6: owner 3 drops and re-asserts alone during the gap
    req = 4'b0000;
    tick();
    check_state("T6.gap", 4'b0000, 2'd0, 1'b0);
    req = 4'b1000;
    tick();
    check_state("T6.regrant", 4'b1000, 2'd3, 1'b0);
    chk("T6.id_wrap", 32'(gnt_id), 32'd3);

    // T7: release on the same edge the tenure expires -> no preempt
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      tick();
      check_state($sformatf("T7.c%0d", c), 4'b0001, 2'd0, 1'b0);
    end
    req = 4'b0010;
    tick();
    check_state("T7.gap", 4'b0000, 2'd0, 1'b0);
    tick();
    check_state("T7.next", 4'b0010, 2'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
